// File: rtl/sprite_plotter_pkg.sv
// Shared constants and state encoding for the sprite plotter.
package sprite_plotter_pkg;
  localparam int SPR_W = 4;
  localparam int SPR_H = 4;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  localparam logic [COL_W-1:0] BLACK = 3'b000;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
endpackage

// File: rtl/sprite_plotter.sv
// Turns one sprite-draw request into SPR_W*SPR_H registered pixel slots for the VGA adapter,
// applying the bitmap mask, erase colour and screen-edge clipping.
module sprite_plotter #(
  parameter int SPR_W = sprite_plotter_pkg::SPR_W,
  parameter int SPR_H = sprite_plotter_pkg::SPR_H,
  parameter int X_W   = sprite_plotter_pkg::X_W,
  parameter int Y_W   = sprite_plotter_pkg::Y_W,
  parameter int COL_W = sprite_plotter_pkg::COL_W,
  parameter int SCR_W = sprite_plotter_pkg::SCR_W,
  parameter int SCR_H = sprite_plotter_pkg::SCR_H
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [X_W-1:0]         req_x,
  input  logic [Y_W-1:0]         req_y,
  input  logic [COL_W-1:0]       req_colour,
  input  logic                   req_erase,
  input  logic [SPR_W*SPR_H-1:0] req_mask,
  output logic                   busy,
  output logic                   done,
  output logic [X_W-1:0]         x_out,
  output logic [Y_W-1:0]         y_out,
  output logic [COL_W-1:0]       colour_out,
  output logic                   plot
);
  import sprite_plotter_pkg::state_t;
  import sprite_plotter_pkg::IDLE;
  import sprite_plotter_pkg::DRAW;
  import sprite_plotter_pkg::DONE;
  import sprite_plotter_pkg::BLACK;

  localparam int SLOTS = SPR_W * SPR_H;
  localparam int CW    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int IW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_t state, state_nx;

  logic [X_W-1:0]   base_x;
  logic [Y_W-1:0]   base_y;
  logic [COL_W-1:0] base_colour;
  logic             base_erase;
  logic [SLOTS-1:0] base_mask;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             last;

  logic             accept, emit;
  logic [X_W-1:0]   src_x;
  logic [Y_W-1:0]   src_y;
  logic [COL_W-1:0] src_colour;
  logic             src_erase;
  logic [SLOTS-1:0] src_mask;
  logic [CW-1:0]    src_col;
  logic [RW-1:0]    src_row;
  logic [IW-1:0]    idx;
  logic [X_W:0]     px;
  logic [Y_W:0]     py;
  logic             hit, slot_last;

  assign accept    = (state == IDLE) && req_valid;
  assign emit      = accept || ((state == DRAW) && !last);
  assign req_ready = (state == IDLE) && reset_n;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Slot 0 is evaluated straight from the request in the accept cycle so the
  // first pixel is visible immediately after acceptance.
  always_comb begin
    src_x      = base_x;
    src_y      = base_y;
    src_colour = base_colour;
    src_erase  = base_erase;
    src_mask   = base_mask;
    src_col    = col;
    src_row    = row;
    if (state == IDLE) begin
      src_x      = req_x;
      src_y      = req_y;
      src_colour = req_colour;
      src_erase  = req_erase;
      src_mask   = req_mask;
      src_col    = '0;
      src_row    = '0;
    end
  end

  // Extra coordinate bit keeps off-screen pixels from folding back to column/row 0.
  assign px        = {1'b0, src_x} + (X_W+1)'(src_col);
  assign py        = {1'b0, src_y} + (Y_W+1)'(src_row);
  assign idx       = IW'(src_row) * IW'(SPR_W) + IW'(src_col);
  assign hit       = src_mask[idx] && (px < (X_W+1)'(SCR_W)) && (py < (Y_W+1)'(SCR_H));
  assign slot_last = (src_col == CW'(SPR_W-1)) && (src_row == RW'(SPR_H-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = DRAW;
      DRAW:    if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_x      <= '0;
      base_y      <= '0;
      base_colour <= '0;
      base_erase  <= 1'b0;
      base_mask   <= '0;
      col         <= '0;
      row         <= '0;
      last        <= 1'b0;
      plot        <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      colour_out  <= '0;
    end else begin
      plot <= 1'b0;
      if (accept) begin
        base_x      <= req_x;
        base_y      <= req_y;
        base_colour <= req_colour;
        base_erase  <= req_erase;
        base_mask   <= req_mask;
      end
      if (emit) begin
        last <= slot_last;
        if (src_col == CW'(SPR_W-1)) begin
          col <= '0;
          row <= src_row + RW'(1);
        end else begin
          col <= src_col + CW'(1);
          row <= src_row;
        end
        if (hit) begin
          plot       <= 1'b1;
          x_out      <= px[X_W-1:0];
          y_out      <= py[Y_W-1:0];
          colour_out <= src_erase ? COL_W'(BLACK) : src_colour;
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_plotter.sv
// Randomised scoreboard bench for sprite_plotter: expected pixels/done times are queued at
// request time and a negedge monitor checks every strobe against them.
module tb_sprite_plotter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_x = '0;
  logic [6:0]  req_y = '0;
  logic [2:0]  req_colour = '0;
  logic        req_erase = 1'b0;
  logic [15:0] req_mask = '0;
  logic        busy, done, plot;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;

  sprite_plotter dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_erase(req_erase),
    .req_mask(req_mask), .busy(busy), .done(done), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .plot(plot)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {int t; int x; int y; int c;} pix_t;
  pix_t exp_q[$];
  int   done_q[$];
  pix_t p;
  int   cur_e = -1000;
  int   last_x = 0, last_y = 0, last_c = 0;
  bit   started = 1'b0;
  int   n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference: each set mask bit within the screen becomes one pixel, slot s visible s edges after accept.
  task automatic model(input int e, input int x, input int y, input int c, input bit er,
                       input logic [15:0] m);
    pix_t q;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (m[r*4+cc] && (x + cc) < 160 && (y + r) < 120) begin
          q.t = e + r*4 + cc; q.x = x + cc; q.y = y + r; q.c = er ? 0 : c;
          exp_q.push_back(q);
        end
    done_q.push_back(e + 16);
  endtask

  always @(negedge clk) begin
    if (reset_n && started) begin
      chk("busy", int'(busy), int'(edge_cnt >= cur_e && edge_cnt <= cur_e + 16));
      chk("req_ready", int'(req_ready), int'(!(edge_cnt >= cur_e && edge_cnt <= cur_e + 16)));
      if (plot) begin
        if (exp_q.size() == 0) chk("unexpected_plot", 1, 0);
        else begin
          p = exp_q.pop_front();
          chk("plot_time", edge_cnt, p.t);
          chk("x_out", int'(x_out), p.x);
          chk("y_out", int'(y_out), p.y);
          chk("colour_out", int'(colour_out), p.c);
        end
        last_x = x_out; last_y = y_out; last_c = colour_out;
      end else begin
        chk("hold_xyc", int'({x_out, y_out, colour_out}), (last_x << 10) | (last_y << 3) | last_c);
      end
      while (exp_q.size() > 0 && exp_q[0].t < edge_cnt) begin
        chk("missed_plot_at", exp_q[0].t, edge_cnt);
        void'(exp_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_time", edge_cnt, done_q.pop_front());
      end
      while (done_q.size() > 0 && done_q[0] < edge_cnt) begin
        chk("missed_done_at", done_q[0], edge_cnt);
        void'(done_q.pop_front());
      end
    end
  end

  task automatic send(input int x, input int y, input int c, input bit er,
                      input logic [15:0] m, input bit keep, output int e_acc);
    bit ok = 1'b0;
    e_acc = -1;
    @(negedge clk);
    req_x = 8'(x); req_y = 7'(y); req_colour = 3'(c); req_erase = er; req_mask = m;
    req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (req_ready) begin
        e_acc = edge_cnt + 1;
        cur_e = e_acc;
        model(e_acc, x, y, c, er, m);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0 && done_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1, e2, x, y;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_xyc", int'({x_out, y_out, colour_out}), 0);
    chk("rst_ready_low", int'(req_ready), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    #1 chk("ready_after_rst", int'(req_ready), 1);
    started = 1'b1;

    send(10, 20, 3'b100, 1'b0, 16'hFFFF, 1'b0, e1); wait_idle();
    send(50, 60, 3'b010, 1'b0, 16'h8001, 1'b0, e1); wait_idle();
    send(158, 118, 3'b011, 1'b0, 16'hFFFF, 1'b0, e1); wait_idle();
    send(70, 40, 3'b111, 1'b1, 16'hFFFF, 1'b0, e1); wait_idle();

    // Abort mid-draw with reset; nothing from this request may appear afterwards.
    send(30, 30, 3'b101, 1'b0, 16'hFFFF, 1'b0, e1);
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b0;
    exp_q.delete(); done_q.delete(); cur_e = -1000;
    last_x = 0; last_y = 0; last_c = 0;
    #1;
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    #1 chk("ready_after_abort", int'(req_ready), 1);
    send(100, 50, 3'b001, 1'b0, 16'h5A5A, 1'b0, e1); wait_idle();

    send(20, 10, 3'b110, 1'b0, 16'hF00F, 1'b1, e1);
    send(24, 10, 3'b011, 1'b0, 16'h0FF0, 1'b0, e2);
    chk("b2b_gap", e2 - e1, 18);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(x, y, $urandom_range(0, 7), 1'($urandom_range(0, 1)), 16'($urandom),
           (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0, e1);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("plot_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
